// File: rtl/pipelined_adder_tree_acc_if.sv
// rtl/pipelined_adder_tree_acc_if.sv - beat input and result bundle for the adder tree accumulator
interface pipelined_adder_tree_acc_if #(
   parameter int NUM_INPUTS = 12,
   parameter int INPUT_SIZE = 12,
   parameter int ACC_SIZE   = 32,
   parameter int TREE_SIZE  = INPUT_SIZE + $clog2(NUM_INPUTS)
);
   logic                                  advance;
   logic                                  in_valid;
   logic                                  in_first;
   logic                                  in_last;
   logic [NUM_INPUTS-1:0][INPUT_SIZE-1:0] data;
   logic [TREE_SIZE-1:0]                  tree_result;
   logic                                  tree_valid;
   logic [ACC_SIZE-1:0]                   acc_result;
   logic                                  acc_valid;

   modport master (
      output advance, in_valid, in_first, in_last, data,
      input  tree_result, tree_valid, acc_result, acc_valid
   );

   modport slave (
      input  advance, in_valid, in_first, in_last, data,
      output tree_result, tree_valid, acc_result, acc_valid
   );
endinterface

// File: rtl/pipelined_adder_tree_acc.sv
// rtl/pipelined_adder_tree_acc.sv - stallable pipelined adder tree with framed accumulator
module pipelined_adder_tree_acc #(
   parameter int NUM_INPUTS = 12,
   parameter int INPUT_SIZE = 12,
   parameter int SIGNED     = 1,
   parameter int ACC_SIZE   = 32
) (
   input logic                        clk,
   input logic                        rst,
   pipelined_adder_tree_acc_if.slave  bus
);
   localparam int NUM_STAGES = $clog2(NUM_INPUTS);
   localparam int TREE_SIZE  = INPUT_SIZE + NUM_STAGES;

   // Each stage halves the operand count (rounding up) and grows one bit,
   // so the final stage holds a single TREE_SIZE-wide sum with no overflow.
   for (genvar s = 0; s < NUM_STAGES; s++) begin : gen_stage
      localparam int IN_W  = INPUT_SIZE + s;
      localparam int OUT_W = IN_W + 1;
      localparam int N_IN  = (NUM_INPUTS + (1 << s) - 1) >> s;
      localparam int N_OUT = (N_IN + 1) / 2;

      logic [IN_W-1:0]  a   [N_IN];
      logic [OUT_W-1:0] ea  [N_IN];
      logic [OUT_W-1:0] nxt [N_OUT];
      logic [OUT_W-1:0] q   [N_OUT];

      for (genvar i = 0; i < N_IN; i++) begin : gen_ext
         if (s == 0) begin : gen_src_in
            assign a[i] = bus.data[i];
         end else begin : gen_src_prev
            assign a[i] = gen_stage[s-1].q[i];
         end
         if (SIGNED != 0) begin : gen_sext
            assign ea[i] = OUT_W'($signed(a[i]));
         end else begin : gen_zext
            assign ea[i] = OUT_W'(a[i]);
         end
      end

      // Odd leftover operand passes through, already widened by ea.
      for (genvar j = 0; j < N_OUT; j++) begin : gen_pair
         if (2*j + 1 < N_IN) begin : gen_add
            assign nxt[j] = ea[2*j] + ea[2*j+1];
         end else begin : gen_pass
            assign nxt[j] = ea[2*j];
         end
      end

      // Stage register: captures partial sums only on advancing cycles
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int k = 0; k < N_OUT; k++) q[k] <= '0;
         end else if (bus.advance) begin
            for (int k = 0; k < N_OUT; k++) q[k] <= nxt[k];
         end
      end
   end

   logic [NUM_STAGES-1:0] v_q;
   logic [NUM_STAGES-1:0] f_q;
   logic [NUM_STAGES-1:0] l_q;
   logic [TREE_SIZE-1:0]  tree_sum;
   logic                  tree_valid;
   logic                  tree_first;
   logic                  tree_last;

   // Sideband shift register; framing flags are masked by valid on entry
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         f_q <= '0;
         l_q <= '0;
      end else if (bus.advance) begin
         v_q <= (v_q << 1) | NUM_STAGES'(bus.in_valid);
         f_q <= (f_q << 1) | NUM_STAGES'(bus.in_valid & bus.in_first);
         l_q <= (l_q << 1) | NUM_STAGES'(bus.in_valid & bus.in_last);
      end
   end

   assign tree_sum   = gen_stage[NUM_STAGES-1].q[0];
   assign tree_valid = v_q[NUM_STAGES-1];
   assign tree_first = f_q[NUM_STAGES-1];
   assign tree_last  = l_q[NUM_STAGES-1];

   logic [ACC_SIZE-1:0] tree_ext;
   logic [ACC_SIZE-1:0] acc_q;
   logic                acc_v_q;

   if (SIGNED != 0) begin : gen_acc_sext
      assign tree_ext = ACC_SIZE'($signed(tree_sum));
   end else begin : gen_acc_zext
      assign tree_ext = ACC_SIZE'(tree_sum);
   end

   // Accumulator: first restarts the frame, otherwise add (wraps); valid marks frame end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         acc_v_q <= 1'b0;
      end else if (bus.advance) begin
         if (tree_valid) begin
            acc_q   <= tree_first ? tree_ext : acc_q + tree_ext;
            acc_v_q <= tree_last;
         end else begin
            acc_v_q <= 1'b0;
         end
      end
   end

   assign bus.tree_result = tree_sum;
   assign bus.tree_valid  = tree_valid;
   assign bus.acc_result  = acc_q;
   assign bus.acc_valid   = acc_v_q;
endmodule

// File: tb/tb_pipelined_adder_tree_acc.sv
// tb/tb_pipelined_adder_tree_acc.sv - scoreboard bench for pipelined_adder_tree_acc
module tb_pipelined_adder_tree_acc;
   localparam int NI = 12;
   localparam int NS = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_adder_tree_acc_if #(.NUM_INPUTS(12), .INPUT_SIZE(12), .ACC_SIZE(32)) bs ();
   pipelined_adder_tree_acc_if #(.NUM_INPUTS(5),  .INPUT_SIZE(12), .ACC_SIZE(32)) b5 ();
   pipelined_adder_tree_acc_if #(.NUM_INPUTS(12), .INPUT_SIZE(12), .ACC_SIZE(32)) bu ();

   pipelined_adder_tree_acc #(.NUM_INPUTS(12), .INPUT_SIZE(12), .SIGNED(1), .ACC_SIZE(32))
      dut_s (.clk(clk), .rst(rst), .bus(bs));
   pipelined_adder_tree_acc #(.NUM_INPUTS(5), .INPUT_SIZE(12), .SIGNED(0), .ACC_SIZE(32))
      dut_u5 (.clk(clk), .rst(rst), .bus(b5));
   pipelined_adder_tree_acc #(.NUM_INPUTS(12), .INPUT_SIZE(12), .SIGNED(0), .ACC_SIZE(32))
      dut_u12 (.clk(clk), .rst(rst), .bus(bu));

   typedef struct {
      int     base;
      int     step;
      bit     first;
      bit     last;
      longint exp_sum;
   } vec_t;

   typedef struct {
      longint val;
      int     due;
   } exp_t;

   int     n_tests = 0;
   int     n_fail  = 0;
   exp_t   tree_q[$];
   exp_t   acc_q[$];
   int     model_acc = 0;
   int     adv_cnt   = 0;
   int     main_cyc  = 0;
   bit     adv_s;
   vec_t   vecs[9];

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor for the signed DUT: pops the scoreboard after each advancing edge
   always @(posedge clk) begin
      exp_t e;
      adv_s = bs.advance && !rst;
      #1;
      main_cyc++;
      if (adv_s) begin
         adv_cnt++;
         if (bs.tree_valid) begin
            if (tree_q.size() == 0) begin
               check("tree_unexpected_valid", 1, 0);
            end else begin
               e = tree_q.pop_front();
               check("tree_value", longint'($signed(bs.tree_result)), e.val);
               check("tree_timing", adv_cnt, e.due);
            end
         end
         if (bs.acc_valid) begin
            if (acc_q.size() == 0) begin
               check("acc_unexpected_valid", 1, 0);
            end else begin
               e = acc_q.pop_front();
               check("acc_value", longint'($signed(bs.acc_result)), e.val);
               check("acc_timing", adv_cnt, e.due);
            end
         end
      end
   end

   task automatic drive_beat(input int base, input int step, input bit first, input bit last,
                             input longint exp_sum);
      exp_t e;
      for (int i = 0; i < NI; i++) bs.data[i] = 12'(base + i * step);
      bs.in_valid = 1'b1;
      bs.in_first = first;
      bs.in_last  = last;
      bs.advance  = 1'b1;
      e.val = exp_sum;
      e.due = adv_cnt + NS;
      tree_q.push_back(e);
      model_acc = first ? int'(exp_sum) : model_acc + int'(exp_sum);
      if (last) begin
         e.val = longint'(model_acc);
         e.due = adv_cnt + NS + 1;
         acc_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit adv);
      bs.in_valid = 1'b0;
      bs.in_first = 1'b0;
      bs.in_last  = 1'b0;
      bs.advance  = adv;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int c0;

      vecs[0] = '{2047,  0, 1'b1, 1'b1, 24564};
      vecs[1] = '{-2048, 0, 1'b1, 1'b1, -24576};
      vecs[2] = '{0,     1, 1'b1, 1'b0, 66};
      vecs[3] = '{-100, 10, 1'b0, 1'b0, -540};
      vecs[4] = '{5,    -1, 1'b0, 1'b1, -6};
      vecs[5] = '{1,     0, 1'b1, 1'b0, 12};
      vecs[6] = '{1,     0, 1'b0, 1'b0, 12};
      vecs[7] = '{1,     0, 1'b0, 1'b1, 12};
      vecs[8] = '{2,     0, 1'b1, 1'b1, 24};

      rst = 1'b1;
      bs.advance = 1'b1; bs.in_valid = 1'b0; bs.in_first = 1'b0; bs.in_last = 1'b0; bs.data = '0;
      b5.advance = 1'b1; b5.in_valid = 1'b0; b5.in_first = 1'b0; b5.in_last = 1'b0; b5.data = '0;
      bu.advance = 1'b1; bu.in_valid = 1'b0; bu.in_first = 1'b0; bu.in_last = 1'b0; bu.data = '0;
      repeat (2) @(negedge clk);
      check("reset_tree_result", bs.tree_result, 0);
      check("reset_tree_valid", bs.tree_valid, 0);
      check("reset_acc_result", bs.acc_result, 0);
      check("reset_acc_valid", bs.acc_valid, 0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back table beats, including a 3-beat frame then a single-beat frame
      for (int v = 0; v < 9; v++)
         drive_beat(vecs[v].base, vecs[v].step, vecs[v].first, vecs[v].last, vecs[v].exp_sum);
      repeat (8) idle(1'b1);

      // Five unsigned operands: odd pass-through, latency 3
      for (int i = 0; i < 5; i++) b5.data[i] = 12'(i + 1);
      b5.in_valid = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         b5.in_valid = 1'b0;
      end while (!b5.tree_valid && cyc < 10);
      check("u5_latency", cyc, 3);
      check("u5_sum", b5.tree_result, 15);
      @(negedge clk);
      check("u5_single_valid", b5.tree_valid, 0);

      // Twelve unsigned operands, three distinct back-to-back beats
      for (int i = 0; i < NI; i++) bu.data[i] = 12'd4095;
      bu.in_valid = 1'b1; bu.in_first = 1'b1; bu.in_last = 1'b1;
      cyc = 0;
      @(negedge clk); cyc++;
      for (int i = 0; i < NI; i++) bu.data[i] = 12'd100;
      @(negedge clk); cyc++;
      for (int i = 0; i < NI; i++) bu.data[i] = 12'd7;
      @(negedge clk); cyc++;
      bu.in_valid = 1'b0;
      while (!bu.tree_valid && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      check("u12_latency", cyc, 4);
      check("u12_beat0", bu.tree_result, 49140);
      @(negedge clk);
      check("u12_beat1_valid", bu.tree_valid, 1);
      check("u12_beat1", bu.tree_result, 1200);
      check("u12_acc0", bu.acc_result, 49140);
      check("u12_acc0_valid", bu.acc_valid, 1);
      @(negedge clk);
      check("u12_beat2", bu.tree_result, 84);
      check("u12_acc1", bu.acc_result, 1200);
      @(negedge clk);
      check("u12_after_valid", bu.tree_valid, 0);
      check("u12_acc2", bu.acc_result, 84);

      // Stall for 3 cycles with the beat at stage 1
      c0 = main_cyc;
      drive_beat(3, 0, 1'b1, 1'b1, 36);
      idle(1'b1);
      repeat (3) idle(1'b0);
      cyc = 0;
      do begin
         idle(1'b1);
         cyc++;
      end while (!bs.tree_valid && cyc < 20);
      check("stall_latency", main_cyc - c0, 7);
      idle(1'b1);
      for (int k = 0; k < 2; k++) begin
         idle(1'b0);
         check("stall_acc_hold_valid", bs.acc_valid, 1);
         check("stall_acc_hold_value", bs.acc_result, 36);
      end
      idle(1'b1);
      check("acc_valid_drops", bs.acc_valid, 0);

      // Reset with two beats of an open frame in flight, advance low
      drive_beat(1, 0, 1'b1, 1'b0, 12);
      drive_beat(1, 0, 1'b0, 1'b0, 12);
      rst = 1'b1;
      bs.advance = 1'b0;
      bs.in_valid = 1'b0;
      tree_q.delete();
      acc_q.delete();
      model_acc = 0;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_tree_valid", bs.tree_valid, 0);
      check("midrst_acc_valid", bs.acc_valid, 0);
      check("midrst_tree_result", bs.tree_result, 0);
      check("midrst_acc_result", bs.acc_result, 0);
      repeat (6) idle(1'b1);
      drive_beat(7, 0, 1'b1, 1'b1, 84);
      drive_beat(1, 0, 1'b0, 1'b1, 12);
      repeat (8) idle(1'b1);

      check("tree_queue_drained", tree_q.size(), 0);
      check("acc_queue_drained", acc_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pipelined_adder_tree_acc.md
# pipelined_adder_tree_acc

Parametrised, stallable pipelined adder tree with valid tracking, signed/unsigned mode, arbitrary (non-power-of-two) input count, and a trailing multi-beat accumulator. It reduces NUM_INPUTS operands per beat to one sum. It then optionally accumulates successive beats (first/last framed) into a wide result, for dot products longer than one vector. It sits in the custom execution unit behind the multiplier array, under the same `advance` stall control as the core pipeline.

## Interface

- NUM_INPUTS, 12: operands per beat; must be ≥ 2; need not be a power of two.
- INPUT_SIZE, 12: width of each operand.
- SIGNED, 1: 1 = operands are two's complement and are sign-extended; 0 = operands are zero-extended.
- ACC_SIZE, 32: accumulator width; must be ≥ TREE_SIZE.
- NUM_STAGES, $clog2(NUM_INPUTS): derived; tree depth in registered stages.
- TREE_SIZE, INPUT_SIZE+NUM_STAGES: derived; width of the tree sum.

Ports (one clock; reset is synchronous and active-high):

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- advance  in  1  pipeline enable; 0 freezes every register, including the accumulator.
- in_valid  in  1  the beat on `data` is valid.
- in_first  in  1  the beat starts an accumulation frame; meaningful only with in_valid.
- in_last  in  1  the beat ends an accumulation frame; meaningful only with in_valid.
- data  in  NUM_INPUTS×INPUT_SIZE  packed operands; operand i is data[i].
- tree_result  out  TREE_SIZE  registered sum of one beat.
- tree_valid  out  1  tree_result holds a valid beat.
- acc_result  out  ACC_SIZE  registered accumulator value.
- acc_valid  out  1  acc_result holds a completed frame.

## Operation

- Stage s (0..NUM_STAGES-1) holds ceil(NUM_INPUTS/2^(s+1)) entries, each INPUT_SIZE+s+1 bits wide.
  - Entry j = ext(in[2j]) + ext(in[2j+1]).
  - If stage s has an odd input count, the last input passes through unchanged and is extended by 1 bit.
- ext() follows SIGNED and is applied at every width step.
- No overflow is possible inside the tree, because TREE_SIZE covers the worst case.
- A sideband of valid, first and last flags travels with each beat, one register per stage.
  - Flags whose beat is invalid are ignored.
- Accumulator stage, on a valid tree output while advance=1:
  - first=1: acc ← ext(tree_result) to ACC_SIZE.
  - first=0: acc ← acc + ext(tree_result), wrapping modulo 2^ACC_SIZE.
  - acc_valid is registered with the value of `last` for that beat.
  - A valid tree output with advance=1 and last=0 drives acc_valid to 0.
- A valid tree output with advance=1 updates the accumulator even while acc_valid is high.
- first=1 and last=1 on the same beat: single-beat frame; acc_result equals that beat's sum.
- A beat with first=0 and no open frame accumulates onto the stale acc. This is legal and not flagged.
- Invalid beats (in_valid=0) never modify the accumulator.
- rst (while clk runs), regardless of advance:
  - All stage registers, tree_result and acc_result go to 0.
  - All valid flags, tree_valid and acc_valid go to 0.
  - In-flight beats are discarded.

## Timing

- Reset values: tree_result=0, tree_valid=0, acc_result=0, acc_valid=0.
- Tree latency is NUM_STAGES advancing edges.
  - With advance held 1, a beat sampled at edge t appears on tree_result/tree_valid after edge t+NUM_STAGES-1, i.e. NUM_STAGES cycles later.
- The accumulator adds 1 advancing edge.
  - acc_result/acc_valid appear one cycle after tree_valid.
- Throughput: one beat per advancing cycle; no bubbles are required between frames.
- advance=0: every register holds, including valids.
  - Outputs are frozen and stay asserted for the duration of the stall.
  - On resume, latency is extended exactly by the stall length.
- acc_valid is high for exactly one advancing cycle per last beat, unless the next valid tree beat is also last.
- Inputs are sampled only on edges with advance=1.

## Test plan

- NUM_INPUTS=12, INPUT_SIZE=12, SIGNED=1, advance=1:
  - all operands 2047 → tree_result=24564, tree_valid=1 exactly 4 cycles after the input edge.
  - all operands -2048 → tree_result=-24576 (16-bit 0xA000).
- NUM_INPUTS=5, SIGNED=0: operands 1,2,3,4,5 → tree_result=15 after 3 cycles. This exercises the odd pass-through.
- NUM_INPUTS=12, SIGNED=0: all operands 4095 → 49140. Also check back-to-back beats with distinct values; each appears on consecutive cycles.
- Accumulation: three beats of all-ones (sum 12), first on beat 0 and last on beat 2, then a single beat of all-twos with first=last=1.
  - acc_result=36 with a one-cycle acc_valid at edge t+6.
  - Then acc_result=24 one cycle later.
- Stall: drop advance for 3 cycles while a beat is at stage 1 → the result appears 3 cycles late with the correct value, and no duplicate valid occurs.
- Reset mid-frame:
  - Assert rst for 1 cycle with 2 beats in flight → tree_valid, acc_valid and all results read 0.
  - A subsequent first=last beat yields only its own sum.
